// File: rtl/rtc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rtc_pkg
// Description : Shared types and constants for the RTC frame read sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package rtc_pkg;

    localparam int N_REGS = 11;

    localparam logic [3:0] IDX_SEG    = 4'd0;
    localparam logic [3:0] IDX_MIN    = 4'd1;
    localparam logic [3:0] IDX_HORA   = 4'd2;
    localparam logic [3:0] IDX_DIA    = 4'd3;
    localparam logic [3:0] IDX_MES    = 4'd4;
    localparam logic [3:0] IDX_ANO    = 4'd5;
    localparam logic [3:0] IDX_DSEM   = 4'd6;
    localparam logic [3:0] IDX_NSEM   = 4'd7;
    localparam logic [3:0] IDX_SEG_T  = 4'd8;
    localparam logic [3:0] IDX_MIN_T  = 4'd9;
    localparam logic [3:0] IDX_HORA_T = 4'd10;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_HOLD = 3'd2,
        ST_READ = 3'd3,
        ST_GAP  = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    // RTC register address for each display slot
    function automatic logic [7:0] reg_addr(input logic [3:0] idx);
        case (idx)
            IDX_SEG:    reg_addr = 8'h21;
            IDX_MIN:    reg_addr = 8'h22;
            IDX_HORA:   reg_addr = 8'h23;
            IDX_DIA:    reg_addr = 8'h24;
            IDX_MES:    reg_addr = 8'h25;
            IDX_ANO:    reg_addr = 8'h26;
            IDX_DSEM:   reg_addr = 8'h27;
            IDX_NSEM:   reg_addr = 8'h28;
            IDX_SEG_T:  reg_addr = 8'h41;
            IDX_MIN_T:  reg_addr = 8'h42;
            IDX_HORA_T: reg_addr = 8'h43;
            default:    reg_addr = 8'h00;
        endcase
    endfunction

    // Phase length minus one; a length of 0 behaves as 1
    function automatic logic [7:0] phase_m1(input int len);
        phase_m1 = (len <= 1) ? 8'd0 : 8'(len - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rtc_refresh_timer.sv
`default_nettype none
// ============================================================================
// Module      : rtc_refresh_timer
// Description : Free-running refresh period counter, one-cycle tick on wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module rtc_refresh_timer #(
    parameter logic [15:0] REFRESH = 16'd50000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_auto_en,
    output logic o_tick
);

    localparam logic [15:0] c_last = (REFRESH == 16'd0) ? 16'd0 : REFRESH - 16'd1;

    logic [15:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= 16'd0;
        end else if (!i_auto_en) begin
            r_count <= 16'd0;
        end else if (r_count >= c_last) begin
            r_count <= 16'd0;
        end else begin
            r_count <= r_count + 16'd1;
        end
    end

    assign o_tick = i_auto_en && (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/rtc_read_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : rtc_read_sequencer
// Description : Reads the 11 RTC time registers over the multiplexed A/D bus
//               and forwards each byte to the display register file.
// Revision    : 1.0 - initial release
// ============================================================================
module rtc_read_sequencer
    import rtc_pkg::*;
#(
    parameter int          T_AS    = 4,
    parameter int          T_AH    = 2,
    parameter int          T_RD    = 6,
    parameter int          T_GAP   = 2,
    parameter logic [15:0] REFRESH = 16'd50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       auto_en,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       cs_n,
    output logic       a_d,
    output logic       wr_n,
    output logic       rd_n,
    output logic       wr_en,
    output logic [3:0] wr_idx,
    output logic [7:0] wr_data,
    output logic       busy,
    output logic       done
);

    localparam logic [7:0] c_as_m1  = phase_m1(T_AS);
    localparam logic [7:0] c_ah_m1  = phase_m1(T_AH);
    localparam logic [7:0] c_rd_m1  = phase_m1(T_RD);
    localparam logic [7:0] c_gap_m1 = phase_m1(T_GAP);

    state_t     r_state;
    state_t     w_next_state;
    logic [7:0] r_phase;
    logic [7:0] w_reload;
    logic [3:0] r_idx;
    logic [7:0] r_data;
    logic       w_tick;
    logic       w_trigger;
    logic       w_last;

    rtc_refresh_timer #(
        .REFRESH (REFRESH)
    ) u_refresh (
        .clk       (clk),
        .reset     (reset),
        .i_auto_en (auto_en),
        .o_tick    (w_tick)
    );

    assign w_trigger = start | w_tick;
    assign w_last    = (r_phase == 8'd0);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_trigger) w_next_state = ST_ADDR;
            ST_ADDR: if (w_last)    w_next_state = ST_HOLD;
            ST_HOLD: if (w_last)    w_next_state = ST_READ;
            ST_READ: if (w_last)    w_next_state = ST_GAP;
            ST_GAP:  if (w_last)    w_next_state = (r_idx == IDX_HORA_T) ? ST_DONE : ST_ADDR;
            ST_DONE:                w_next_state = ST_IDLE;
            default:                w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_reload = 8'd0;
        case (w_next_state)
            ST_ADDR: w_reload = c_as_m1;
            ST_HOLD: w_reload = c_ah_m1;
            ST_READ: w_reload = c_rd_m1;
            ST_GAP:  w_reload = c_gap_m1;
            default: w_reload = 8'd0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_phase <= 8'd0;
            r_idx   <= 4'd0;
            r_data  <= 8'd0;
        end else begin
            r_state <= w_next_state;
            if (w_next_state != r_state) begin
                r_phase <= w_reload;
            end else if (!w_last) begin
                r_phase <= r_phase - 8'd1;
            end
            if (r_state == ST_IDLE && w_trigger) begin
                r_idx <= 4'd0;
            end else if (r_state == ST_GAP && w_last && r_idx != IDX_HORA_T) begin
                r_idx <= r_idx + 4'd1;
            end
            if (r_state == ST_READ && w_last) begin
                r_data <= ad_in;
            end
        end
    end

    // Bus outputs decode straight from state so reset releases the pads at once
    always_comb begin
        ad_out = 8'd0;
        ad_oe  = 1'b0;
        cs_n   = 1'b1;
        a_d    = 1'b1;
        wr_n   = 1'b1;
        rd_n   = 1'b1;
        wr_en  = 1'b0;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            ST_ADDR: begin
                ad_out = reg_addr(r_idx);
                ad_oe  = 1'b1;
                cs_n   = 1'b0;
                a_d    = 1'b0;
                wr_n   = 1'b0;
                busy   = 1'b1;
            end
            ST_HOLD: begin
                ad_out = reg_addr(r_idx);
                ad_oe  = 1'b1;
                cs_n   = 1'b0;
                a_d    = 1'b0;
                busy   = 1'b1;
            end
            ST_READ: begin
                cs_n = 1'b0;
                rd_n = 1'b0;
                busy = 1'b1;
            end
            ST_GAP: begin
                wr_en = (r_phase == c_gap_m1);
                busy  = 1'b1;
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    assign wr_idx  = r_idx;
    assign wr_data = r_data;

endmodule
`default_nettype wire

// File: tb/tb_rtc_read_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_rtc_read_sequencer
// Description : Directed self-checking bench for rtc_read_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rtc_read_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       auto_en = 1'b0;
    logic [7:0] ad_in;
    logic [7:0] ad_out;
    logic       ad_oe, cs_n, a_d, wr_n, rd_n, wr_en, busy, done;
    logic [3:0] wr_idx;
    logic [7:0] wr_data;

    rtc_read_sequencer #(
        .T_AS    (4),
        .T_AH    (2),
        .T_RD    (6),
        .T_GAP   (2),
        .REFRESH (16'd300)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .auto_en (auto_en),
        .ad_in   (ad_in),
        .ad_out  (ad_out),
        .ad_oe   (ad_oe),
        .cs_n    (cs_n),
        .a_d     (a_d),
        .wr_n    (wr_n),
        .rd_n    (rd_n),
        .wr_en   (wr_en),
        .wr_idx  (wr_idx),
        .wr_data (wr_data),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    int pc = 0;
    always @(posedge clk) pc++;

    int checks = 0;
    int errors = 0;
    int r_p0 = 0;
    bit tracking = 1'b0;
    bit bus_chk = 1'b0;
    int n_wr = 0;
    int n_done = 0;
    int wr_total = 0;
    int done_total = 0;

    // RTC model: latches the address while wr_n is low, answers 10h + slot
    logic [7:0] lat_addr = 8'h00;
    always @(posedge clk) if (!wr_n) lat_addr <= ad_out;

    function automatic logic [7:0] rtc_data(input logic [7:0] a);
        logic [7:0] slot;
        slot = (a[7:4] == 4'h2) ? ({4'h0, a[3:0]} - 8'd1) : ({4'h0, a[3:0]} + 8'd7);
        return 8'h10 + slot;
    endfunction

    assign ad_in = rtc_data(lat_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        int c;
        c = pc - r_p0 + 1;
        if (wr_en) wr_total++;
        if (done) done_total++;
        if (tracking && c >= 1) begin
            if (wr_en) begin
                chk("wr_idx", {28'd0, wr_idx}, n_wr);
                chk("wr_data", {24'd0, wr_data}, 32'h10 + n_wr);
                chk("wr_cycle", c, 13 + 14 * n_wr);
                n_wr++;
            end
            if (done) begin
                chk("done_cycle", c, 155);
                n_done++;
            end
            if (c <= 160) chk("busy", {31'd0, busy}, {31'd0, (c <= 154)});
            chk("oe_rd_overlap", {31'd0, ad_oe & ~rd_n}, 0);
            if (bus_chk && c >= 43 && c <= 54) begin
                chk("bus_cs_n", {31'd0, cs_n}, 0);
                chk("bus_wr_n", {31'd0, wr_n}, {31'd0, (c > 46)});
                chk("bus_rd_n", {31'd0, rd_n}, {31'd0, (c < 49)});
                chk("bus_ad_oe", {31'd0, ad_oe}, {31'd0, (c <= 48)});
                chk("bus_a_d", {31'd0, a_d}, {31'd0, (c >= 49)});
                if (c <= 48) chk("bus_ad_out", {24'd0, ad_out}, 32'h24);
            end
        end
    end

    // Follows one frame whose trigger edge leaves pc == p0
    task automatic track(input int p0, input bit pulses, input bit bus);
        r_p0 = p0;
        n_wr = 0;
        n_done = 0;
        bus_chk = bus;
        tracking = 1'b1;
        do begin
            @(negedge clk);
            start = pulses && ((pc - r_p0 + 1) == 40 || (pc - r_p0 + 1) == 154);
        end while (pc - r_p0 + 1 < 200);
        tracking = 1'b0;
        chk("frame_writes", n_wr, 11);
        chk("frame_dones", n_done, 1);
    endtask

    initial begin
        int w0;
        int d1;
        int p;

        #1;
        chk("rst_cs_n", {31'd0, cs_n}, 1);
        chk("rst_wr_n", {31'd0, wr_n}, 1);
        chk("rst_rd_n", {31'd0, rd_n}, 1);
        chk("rst_a_d", {31'd0, a_d}, 1);
        chk("rst_ad_oe", {31'd0, ad_oe}, 0);
        chk("rst_ad_out", {24'd0, ad_out}, 0);
        chk("rst_wr_en", {31'd0, wr_en}, 0);
        chk("rst_wr_idx", {28'd0, wr_idx}, 0);
        chk("rst_wr_data", {24'd0, wr_data}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);

        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        start = 1'b1;
        track(pc + 1, 1'b0, 1'b1);

        repeat (5) @(negedge clk);
        start = 1'b1;
        track(pc + 1, 1'b1, 1'b0);

        // Abort a frame while register 4 is in its address phase
        repeat (5) @(negedge clk);
        start = 1'b1;
        r_p0 = pc + 1;
        while (pc - r_p0 + 1 < 60) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("pre_rst_ad_out", {24'd0, ad_out}, 32'h25);
        chk("pre_rst_wr_n", {31'd0, wr_n}, 0);
        w0 = wr_total;
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_cs_n", {31'd0, cs_n}, 1);
        chk("mid_rst_wr_n", {31'd0, wr_n}, 1);
        chk("mid_rst_rd_n", {31'd0, rd_n}, 1);
        chk("mid_rst_ad_oe", {31'd0, ad_oe}, 0);
        chk("mid_rst_a_d", {31'd0, a_d}, 1);
        chk("mid_rst_busy", {31'd0, busy}, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        chk("no_wr_after_reset", wr_total, w0);
        start = 1'b1;
        track(pc + 1, 1'b0, 1'b0);

        // Auto refresh: first tick 300 edges after enabling, then every 300
        repeat (5) @(negedge clk);
        auto_en = 1'b1;
        track(pc + 1 + 299, 1'b0, 1'b0);
        track(r_p0 + 300, 1'b0, 1'b0);
        auto_en = 1'b0;
        d1 = done_total;
        repeat (700) @(negedge clk);
        chk("auto_stopped", done_total, d1);

        // start coinciding with the refresh tick
        repeat (5) @(negedge clk);
        auto_en = 1'b1;
        p = pc + 1 + 299;
        while (pc < p - 1) @(negedge clk);
        start = 1'b1;
        track(p, 1'b0, 1'b0);
        auto_en = 1'b0;
        d1 = done_total;
        repeat (50) @(negedge clk);
        chk("coincide_no_extra", done_total, d1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
